// File: rtl/board_eval.sv
// board_eval: walks COUNT 64-square boards in memory, writes each material score
// and tracks the best score and its index. Avalon-style slave regs and read/write master.
module board_eval (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, WR_SCORE = 3'd3, NEXT = 3'd4, DONE = 3'd5;
    logic [2:0]  state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, acc_q, acc_d, best_q, best_d, bidx_q, bidx_d;
    logic [5:0]  sq_q, sq_d;
    logic [7:0]  brd_q, brd_d;
    logic        done_q, done_d, err_q, err_d;
    logic        busy, wr, start;
    logic [7:0]  code, mag;
    logic [3:0]  val;
    logic [31:0] rdata;

    assign busy  = state_q >= RD_REQ && state_q <= NEXT;
    assign wr    = slave_write && !busy;
    assign start = wr && slave_address == 4'd0;

    assign code = master_readdata[7:0];
    assign mag  = code[7] ? ~code + 8'd1 : code;
    assign val  = mag == 8'd0  ? 4'd0 :
                  mag <= 8'd8  ? 4'd1 :
                  mag <= 8'd18 ? 4'd5 :
                  mag <= 8'd38 ? 4'd3 :
                  mag <= 8'd47 ? 4'd9 : 4'd0;

    assign master_read      = state_q == RD_REQ;
    assign master_write     = state_q == WR_SCORE;
    assign master_address   = state_q == RD_REQ   ? src_q + {18'd0, brd_q, sq_q} :
                              state_q == WR_SCORE ? dst_q + {22'd0, brd_q, 2'd0} : '0;
    assign master_writedata = state_q == WR_SCORE ? acc_q : '0;

    assign slave_waitrequest = slave_read && slave_address == 4'd0 && busy;
    assign rdata = slave_address == 4'd0 ? {30'd0, err_q, done_q} :
                   slave_address == 4'd1 ? src_q :
                   slave_address == 4'd2 ? dst_q :
                   slave_address == 4'd3 ? cnt_q :
                   slave_address == 4'd4 ? best_q :
                   slave_address == 4'd5 ? bidx_q : '0;
    // gated by rst_n so reset forces the bus to zero even mid-read
    assign slave_readdata = (rst_n && slave_read && !slave_waitrequest) ? rdata : '0;

    always_comb begin
        state_d = state_q;
        src_d   = wr && slave_address == 4'd1 ? slave_writedata : src_q;
        dst_d   = wr && slave_address == 4'd2 ? slave_writedata : dst_q;
        cnt_d   = wr && slave_address == 4'd3 ? slave_writedata : cnt_q;
        best_d  = wr && slave_address == 4'd4 ? slave_writedata : best_q;
        bidx_d  = wr && slave_address == 4'd5 ? slave_writedata : bidx_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        brd_d   = brd_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    acc_d   = '0;
                    sq_d    = '0;
                    brd_d   = '0;
                    err_d   = 1'b0;
                    best_d  = 32'h8000_0000;
                    bidx_d  = '1;
                    done_d  = cnt_q[7:0] == 8'd0;
                    state_d = cnt_q[7:0] == 8'd0 ? DONE : RD_REQ;
                end
            end
            RD_REQ: state_d = master_waitrequest ? RD_REQ : RD_WAIT;
            RD_WAIT: begin
                if (master_readdatavalid) begin
                    acc_d   = acc_q + (code[7] ? -{28'd0, val} : {28'd0, val});
                    err_d   = err_q | (mag > 8'd48);
                    sq_d    = sq_q + 6'd1;
                    state_d = sq_q == 6'd63 ? WR_SCORE : RD_REQ;
                end
            end
            WR_SCORE: state_d = master_waitrequest ? WR_SCORE : NEXT;
            NEXT: begin
                // strict compare so ties keep the earlier board
                if ($signed(acc_q) > $signed(best_q)) begin
                    best_d = acc_q;
                    bidx_d = {24'd0, brd_q};
                end
                if (brd_q == cnt_q[7:0] - 8'd1) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d   = '0;
                    brd_d   = brd_q + 8'd1;
                    state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            best_q  <= 32'h8000_0000;
            bidx_q  <= '1;
            sq_q    <= '0;
            brd_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            bidx_q  <= bidx_d;
            sq_q    <= sq_d;
            brd_q   <= brd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: memory responder with optional stalls plus a scoreboard of expected score writes.
module tb_board_eval;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        slave_waitrequest, slave_read = 1'b0, slave_write = 1'b0;
    logic [3:0]  slave_address = '0;
    logic [31:0] slave_readdata, slave_writedata = '0;
    logic        master_waitrequest = 1'b0, master_read, master_readdatavalid = 1'b0, master_write;
    logic [31:0] master_address, master_readdata = '0, master_writedata;

    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t sb[$];
    int wr_cyc[$];
    int tests = 0, fails = 0, ws = 0, n_rd = 0, n_acc = 0, n_stall = 0, cyc = 0;
    logic [7:0] mem [2048];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_eval dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_write(master_write),
        .master_writedata(master_writedata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pv(input int m);
        if (m >= 1 && m <= 8) return 1;
        if (m >= 9 && m <= 18) return 5;
        if (m >= 19 && m <= 38) return 3;
        if (m >= 39 && m <= 47) return 9;
        return 0;
    endfunction

    function automatic int score(input logic [31:0] base);
        int s, c;
        logic [31:0] a;
        s = 0;
        for (int k = 0; k < 64; k++) begin
            a = base + 32'(k);
            c = int'($signed(mem[a[10:0]]));
            s += c < 0 ? -pv(-c) : pv(c);
        end
        return s;
    endfunction

    task automatic put(input logic [31:0] base, input int sq, input logic [7:0] v);
        logic [31:0] a;
        a = base + 32'(sq);
        mem[a[10:0]] = v;
    endtask

    task automatic init_board(input logic [31:0] base);
        logic [7:0] v, p;
        for (int k = 0; k < 64; k++) put(base, k, 8'd0);
        for (int f = 0; f < 8; f++) begin
            v = (f == 0 || f == 7) ? 8'd9 : (f == 1 || f == 6) ? 8'd19 : (f == 2 || f == 5) ? 8'd29 : f == 3 ? 8'd39 : 8'd48;
            p = 8'(f + 1);
            put(base, f, v);
            put(base, 56 + f, ~v + 8'd1);
            put(base, 8 + f, p);
            put(base, 48 + f, ~p + 8'd1);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_writedata = d;
        slave_write = 1'b1;
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        slave_address = a;
        slave_read = 1'b1;
        #1;
        n = 0;
        while (slave_waitrequest && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 20000) chk("rd_timeout", 32'(n), 0);
        d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt);
        wr(4'd1, src);
        wr(4'd2, dst);
        wr(4'd3, cnt);
        for (int i = 0; i < int'(cnt[7:0]); i++)
            sb.push_back('{dst + 32'(4 * i), 32'(score(src + 32'(64 * i)))});
        n_rd = 0;
        wr_cyc.delete();
        wr(4'd0, 32'd1);
    endtask

    task automatic finish_run(input logic [31:0] ctrl, input logic [31:0] best, input logic [31:0] idx);
        logic [31:0] d;
        rd(4'd0, d); chk("ctrl", d, ctrl);
        rd(4'd4, d); chk("best", d, best);
        rd(4'd5, d); chk("bestidx", d, idx);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    // memory model: accepts after ws stall cycles, returns read data one cycle after accept
    initial begin
        logic pend;
        logic [7:0] pend_d;
        logic [31:0] sa, sd;
        logic sr, sw;
        int stall;
        wr_t e;
        pend = 1'b0; pend_d = '0; stall = 0; sa = '0; sd = '0; sr = 1'b0; sw = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                stall = 0;
                master_readdatavalid = 1'b0;
                master_waitrequest = 1'b0;
            end else begin
                master_readdatavalid = pend;
                master_readdata = {24'hDEADBE, pend_d};
                pend = 1'b0;
                if (master_read || master_write) begin
                    if (stall > 0) begin
                        chk("stall_addr", master_address, sa);
                        chk("stall_rd", 32'(master_read), 32'(sr));
                        chk("stall_wr", 32'(master_write), 32'(sw));
                        chk("stall_data", master_writedata, sd);
                    end else begin
                        sa = master_address; sr = master_read; sw = master_write; sd = master_writedata;
                    end
                    if (stall < ws) begin
                        stall++;
                        n_stall++;
                        master_waitrequest = 1'b1;
                    end else begin
                        stall = 0;
                        master_waitrequest = 1'b0;
                        n_acc++;
                        if (master_read) begin
                            pend = 1'b1;
                            pend_d = mem[master_address[10:0]];
                            n_rd++;
                        end else if (sb.size() == 0) begin
                            chk("wr_unexpected", 32'(sb.size()), 1);
                        end else begin
                            e = sb.pop_front();
                            wr_cyc.push_back(cyc);
                            chk("wr_addr", master_address, e.a);
                            chk("wr_data", master_writedata, e.d);
                        end
                    end
                end else begin
                    stall = 0;
                    master_waitrequest = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n0, k;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mread", 32'(master_read), 0);
        chk("rst_mwrite", 32'(master_write), 0);
        chk("rst_maddr", master_address, 0);
        rst_n = 1'b1;
        rd(4'd0, d); chk("def_ctrl", d, 0);
        rd(4'd1, d); chk("def_src", d, 0);
        rd(4'd3, d); chk("def_count", d, 0);
        rd(4'd4, d); chk("def_best", d, 32'h8000_0000);
        rd(4'd5, d); chk("def_bestidx", d, 32'hFFFF_FFFF);
        wr(4'd7, 32'd123);
        rd(4'd7, d); chk("unmapped", d, 0);

        // single initial position, plus writes/reads while busy
        init_board(32'h1000);
        start_run(32'h1000, 32'h2000, 32'd1);
        wr(4'd1, 32'hDEAD_0000);
        rd(4'd4, d); chk("busy_best", d, 32'h8000_0000);
        rd(4'd3, d); chk("busy_count", d, 1);
        @(negedge clk);
        slave_address = 4'd0; slave_read = 1'b1;
        #1 chk("busy_wait", 32'(slave_waitrequest), 1);
        slave_read = 1'b0;
        finish_run(32'd1, 32'd0, 32'd0);
        rd(4'd1, d); chk("busy_wr_ignored", d, 32'h1000);

        // two boards: scores 9 and -3, back-to-back writes 130 cycles apart
        init_board(32'h1000); put(32'h1000, 59, 8'd0);
        init_board(32'h1040); put(32'h1040, 1, 8'd0);
        start_run(32'h1000, 32'h2000, 32'd2);
        finish_run(32'd1, 32'd9, 32'd0);
        chk("board_latency", wr_cyc.size() == 2 ? 32'(wr_cyc[1] - wr_cyc[0]) : 32'd0, 130);

        // same boards with 3 stall cycles on every access
        ws = 3;
        start_run(32'h1000, 32'h2000, 32'd2);
        finish_run(32'd1, 32'd9, 32'd0);
        chk("stalls_seen", 32'(n_stall > 0), 1);
        ws = 0;

        // scores 5, 5, 2: tie keeps the lower index
        init_board(32'h1200); put(32'h1200, 56, 8'd0);
        init_board(32'h1240); put(32'h1240, 63, 8'd0);
        init_board(32'h1280); put(32'h1280, 56, 8'd0); put(32'h1280, 1, 8'd0);
        start_run(32'h1200, 32'h3000, 32'd3);
        finish_run(32'd1, 32'd5, 32'd0);

        // illegal code 0x40 adds nothing and raises err
        init_board(32'h1400); put(32'h1400, 20, 8'h40);
        start_run(32'h1400, 32'h2100, 32'd1);
        finish_run(32'd3, 32'd0, 32'd0);

        // 32-bit wrap of both read and write addresses; err cleared by restart
        init_board(32'hFFFF_FFC0); put(32'hFFFF_FFC0, 8, 8'd0);
        init_board(32'h0); put(32'h0, 50, 8'd0); put(32'h0, 57, 8'd0);
        start_run(32'hFFFF_FFC0, 32'hFFFF_FFFC, 32'd2);
        finish_run(32'd1, 32'd4, 32'd1);

        // COUNT=0 finishes immediately with no master traffic
        n0 = n_acc;
        start_run(32'h1000, 32'h2000, 32'd0);
        slave_address = 4'd0; slave_read = 1'b1;
        #1 chk("cnt0_wait", 32'(slave_waitrequest), 0);
        chk("cnt0_ctrl", slave_readdata, 1);
        slave_read = 1'b0;
        rd(4'd5, d); chk("cnt0_bestidx", d, 32'hFFFF_FFFF);
        chk("cnt0_traffic", 32'(n_acc - n0), 0);

        // reset pulse in the middle of the first board
        start_run(32'h1200, 32'h3000, 32'd3);
        k = 0;
        while (n_rd < 30 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_sq30", 32'(n_rd >= 30), 1);
        rst_n = 1'b0;
        slave_address = 4'd4; slave_read = 1'b1;
        #1;
        chk("mid_rst_mread", 32'(master_read), 0);
        chk("mid_rst_mwrite", 32'(master_write), 0);
        chk("mid_rst_maddr", master_address, 0);
        chk("mid_rst_wdata", master_writedata, 0);
        chk("mid_rst_swait", 32'(slave_waitrequest), 0);
        chk("mid_rst_rdata", slave_readdata, 0);
        slave_read = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(4'd0, d); chk("post_rst_ctrl", d, 0);
        rd(4'd2, d); chk("post_rst_dst", d, 0);
        rd(4'd4, d); chk("post_rst_best", d, 32'h8000_0000);
        start_run(32'h1200, 32'h3000, 32'd3);
        finish_run(32'd1, 32'd5, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
